// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter and related shared-resource arbiters.
package uart_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    localparam int NUM_REQ_DEF      = 4;
    localparam int DATA_W_DEF       = 8;
    localparam int IDLE_TIMEOUT_DEF = 1024;
    localparam int WD_W_DEF         = $clog2(IDLE_TIMEOUT_DEF);

    function automatic int wd_width(input int timeout);
        return $clog2(timeout);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request after ptr, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int  NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               any,
    output logic [IW-1:0]      idx
);

    always_comb begin
        any = 1'b0;
        idx = ptr;
        // ptr itself is scanned last, so the previous owner has lowest priority
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!any && req[(int'(ptr) + k) % NUM_REQ]) begin
                any = 1'b1;
                idx = IW'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART TX byte port among NUM_REQ requesters.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int  NUM_REQ      = NUM_REQ_DEF,
    parameter int  DATA_W       = DATA_W_DEF,
    parameter int  IDLE_TIMEOUT = IDLE_TIMEOUT_DEF,
    localparam int GW           = $clog2(NUM_REQ)
) (
    input  logic                       hwclk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_valid,
    output logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_ready,
    output logic [GW-1:0]              grant_id,
    output logic                       busy
);

    localparam int              WD_W    = wd_width(IDLE_TIMEOUT);
    localparam logic [WD_W-1:0] WD_TERM = WD_W'(IDLE_TIMEOUT - 1);

    arb_state_t      state;
    logic [GW-1:0]   rr_ptr;
    logic [WD_W-1:0] wd_cnt;
    logic            pick_any;
    logic [GW-1:0]   pick_idx;
    logic            g_valid;
    logic            g_last;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign g_valid = req_valid[grant_id];
    assign g_last  = req_last[grant_id];
    assign tx_data = req_data[int'(grant_id)*DATA_W +: DATA_W];
    assign busy    = (state == ST_LOCK);

    // Combinational pass-through; reset blocks any handshake in the same cycle
    always_comb begin
        tx_valid  = 1'b0;
        req_ready = '0;
        if (!rst && state == ST_LOCK) begin
            tx_valid            = g_valid;
            req_ready[grant_id] = tx_ready;
        end
    end

    always_ff @(posedge hwclk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= GW'(NUM_REQ - 1);
            grant_id <= '0;
            wd_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wd_cnt <= '0;
                    if (pick_any) begin
                        grant_id <= pick_idx;
                        state    <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (g_valid) begin
                        wd_cnt <= '0;
                        if (tx_ready && g_last) begin
                            rr_ptr <= grant_id;
                            state  <= ST_IDLE;
                        end
                    end else if (wd_cnt == WD_TERM) begin
                        // owner went quiet mid-packet; abandon it
                        wd_cnt <= '0;
                        rr_ptr <= grant_id;
                        state  <= ST_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter against a packet-level reference model.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int DATA_W       = 8;
    localparam int IDLE_TIMEOUT = 16;
    localparam int GW           = $clog2(NUM_REQ);

    logic                      hwclk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_valid;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_ready;
    logic [GW-1:0]             grant_id;
    logic                      busy;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DATA_W       (DATA_W),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) dut (
        .hwclk     (hwclk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 hwclk = ~hwclk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Requester side: each requester streams bytes {last, data} from its own queue
    logic [DATA_W:0] pq [NUM_REQ][$];
    bit              gap [NUM_REQ];
    int              gap_len [NUM_REQ];

    // Reference model: who owns the port, who owned it last, how long the owner has been silent
    bit                 m_owned;
    int                 m_owner;
    int                 m_prev;
    int                 m_gid;
    int                 m_low;
    logic [NUM_REQ-1:0] m_acc;

    task automatic model_reset();
        m_owned = 1'b0;
        m_owner = 0;
        m_prev  = NUM_REQ - 1;
        m_gid   = 0;
        m_low   = 0;
        m_acc   = '0;
    endtask

    task automatic model_step();
        bit found;
        if (rst) begin
            model_reset();
        end else if (!m_owned) begin
            found = 1'b0;
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (!found && req_valid[(m_prev + k) % NUM_REQ]) begin
                    found   = 1'b1;
                    m_owned = 1'b1;
                    m_owner = (m_prev + k) % NUM_REQ;
                    m_gid   = m_owner;
                    m_low   = 0;
                end
            end
        end else if (req_valid[m_owner]) begin
            m_low = 0;
            if (tx_ready && req_last[m_owner]) begin
                m_owned = 1'b0;
                m_prev  = m_owner;
            end
        end else begin
            m_low++;
            if (m_low == IDLE_TIMEOUT) begin
                m_owned = 1'b0;
                m_prev  = m_owner;
                m_low   = 0;
            end
        end
    endtask

    task automatic present();
        logic [DATA_W:0] e;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pq[i].size() > 0 && !gap[i]) begin
                e                            = pq[i][0];
                req_valid[i]                 = 1'b1;
                req_last[i]                  = e[DATA_W];
                req_data[i*DATA_W +: DATA_W] = e[DATA_W-1:0];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic push_pkt(input int i, input int n);
        logic [DATA_W-1:0] d;
        for (int k = 0; k < n; k++) begin
            d = DATA_W'($urandom);
            pq[i].push_back({(k == n - 1), d});
        end
    endtask

    task automatic settle();
        logic [NUM_REQ-1:0] exp_ready;
        logic               exp_valid;
        logic [DATA_W:0]    e;
        #1;
        exp_ready = '0;
        exp_valid = 1'b0;
        if (!rst && m_owned) begin
            exp_valid          = req_valid[m_owner];
            exp_ready[m_owner] = tx_ready;
        end
        m_acc = exp_ready & req_valid;
        check_eq("tx_valid",  32'(tx_valid),  32'(exp_valid));
        check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
        check_eq("busy",      32'(busy),      32'(m_owned));
        check_eq("grant_id",  32'(grant_id),  32'(m_gid));
        if (exp_valid) begin
            e = pq[m_owner][0];
            check_eq("tx_data", 32'(tx_data), 32'(e[DATA_W-1:0]));
        end
    endtask

    task automatic tick();
        @(posedge hwclk);
        model_step();
        for (int i = 0; i < NUM_REQ; i++)
            if (m_acc[i]) void'(pq[i].pop_front());
        @(negedge hwclk);
        present();
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        logic [3:0] pat;
        int         acc;

        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gap[i]     = 1'b0;
            gap_len[i] = 0;
        end
        repeat (2) @(negedge hwclk);
        model_reset();
        cycle();
        rst = 1'b0;
        cycle();

        // single two-byte packet from requester 0
        pq[0].push_back({1'b0, 8'h47});
        pq[0].push_back({1'b1, 8'h0A});
        tx_ready = 1'b1;
        present();
        cycle();
        settle();
        check_eq("t1_grant", 32'(grant_id), 32'd0);
        check_eq("t1_byte0", 32'(tx_data), 32'h47);
        tick();
        settle();
        check_eq("t1_byte1", 32'(tx_data), 32'h0A);
        tick();
        settle();
        check_eq("t1_release", 32'(busy), 32'd0);
        tick();

        // fresh reset, then one-byte packets everywhere: order 0,1,2,3,0 with bubbles
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) push_pkt(i, 1);
        push_pkt(0, 1);
        present();
        for (int g = 0; g < 5; g++) begin
            settle();
            check_eq("t2_bubble", 32'(busy), 32'd0);
            tick();
            settle();
            check_eq("t2_order", 32'(grant_id), 32'(g % NUM_REQ));
            tick();
        end
        cycle();

        // requester 1 waits while requester 2 finishes its packet
        push_pkt(2, 3);
        present();
        cycle();
        settle();
        check_eq("t3_grant2", 32'(grant_id), 32'd2);
        tick();
        push_pkt(1, 2);
        present();
        for (int k = 0; k < 2; k++) begin
            settle();
            check_eq("t3_hold", 32'(req_ready[1]), 32'd0);
            tick();
        end
        cycle();
        settle();
        check_eq("t3_next", 32'(grant_id), 32'd1);
        tick();
        run(3);

        // backpressure pattern 1,0,0,1 under a three-byte packet
        push_pkt(3, 3);
        present();
        cycle();
        pat = 4'b1001;
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            tx_ready = pat[k % 4];
            settle();
            if (req_ready[3] && req_valid[3]) acc++;
            if (m_owned) check_eq("t4_mirror", 32'(req_ready[3]), 32'(tx_ready));
            tick();
        end
        check_eq("t4_beats", 32'(acc), 32'd3);
        tx_ready = 1'b1;

        // owner goes silent after one byte; watchdog hands over to requester 0
        push_pkt(1, 3);
        present();
        cycle();
        settle();
        tick();
        gap[1] = 1'b1;
        push_pkt(0, 1);
        present();
        for (int k = 0; k < IDLE_TIMEOUT; k++) begin
            settle();
            check_eq("t5_hold", 32'(busy), 32'd1);
            tick();
        end
        settle();
        check_eq("t5_release", 32'(busy), 32'd0);
        tick();
        settle();
        check_eq("t5_next", 32'(grant_id), 32'd0);
        tick();
        pq[1].delete();
        gap[1] = 1'b0;
        present();
        run(3);

        // reset in the middle of a packet
        push_pkt(2, 3);
        present();
        cycle();
        settle();
        tick();
        push_pkt(0, 1);
        present();
        rst = 1'b1;
        settle();
        check_eq("t6_rst_ready", 32'(req_ready), 32'd0);
        check_eq("t6_rst_valid", 32'(tx_valid), 32'd0);
        tick();
        rst = 1'b0;
        settle();
        check_eq("t6_busy", 32'(busy), 32'd0);
        check_eq("t6_gid", 32'(grant_id), 32'd0);
        tick();
        settle();
        check_eq("t6_prio", 32'(grant_id), 32'd0);
        tick();
        run(10);

        // random traffic with stalls, gaps, long silences and occasional resets
        for (int c = 0; c < 4000; c++) begin
            tx_ready = ($urandom_range(0, 3) != 0);
            rst      = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pq[i].size() == 0 && $urandom_range(0, 5) == 0)
                    push_pkt(i, $urandom_range(1, 5));
                if (gap_len[i] > 0)
                    gap_len[i]--;
                else if ($urandom_range(0, 99) == 0)
                    gap_len[i] = $urandom_range(1, 25);
                else if ($urandom_range(0, 7) == 0)
                    gap_len[i] = 1;
                gap[i] = (gap_len[i] > 0);
            end
            present();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
